// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : dmem_pkg                                                        |
// | Purpose  : Shared types and decode helpers for the pipelined data memory.  |
// |            MEM_Ctrl encoding, access-size decode, store detect and         |
// |            alignment check.                                                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package dmem_pkg;

  typedef enum logic [3:0] {
    LB  = 4'd0,
    LH  = 4'd1,
    LW  = 4'd2,
    LBU = 4'd3,
    LHU = 4'd4,
    SB  = 4'd5,
    SH  = 4'd6,
    SW  = 4'd7
  } mem_ctrl_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  function automatic logic is_store(input logic [3:0] ctrl);
    return (ctrl == SB) || (ctrl == SH) || (ctrl == SW);
  endfunction

  // Illegal codes (8-15) decode as WORD; they are rejected separately.
  function automatic acc_size_e acc_size(input logic [3:0] ctrl);
    case (ctrl)
      LB, LBU, SB: return SZ_BYTE;
      LH, LHU, SH: return SZ_HALF;
      default:     return SZ_WORD;
    endcase
  endfunction

  function automatic logic misaligned(input logic [3:0] ctrl, input logic [1:0] off);
    case (acc_size(ctrl))
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_load_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmem_load_align                                                 |
// | Purpose  : Combinational load lane select with sign/zero extension.        |
// | Ports    : rdata_word - full array word                                    |
// |            off        - byte offset within the word (addr[1:0])            |
// |            ctrl       - MEM_Ctrl code                                      |
// |            rdata      - extended load result (0 for non-load codes)        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dmem_load_align
  import dmem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_word,
  input  logic [1:0]      off,
  input  logic [3:0]      ctrl,
  output logic [XLEN-1:0] rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata_word[{off, 3'b000} +: 8];
    w_half = off[1] ? rdata_word[31:16] : rdata_word[15:0];
    rdata  = '0;
    case (ctrl)
      LB:      rdata = {{(XLEN-8){w_byte[7]}}, w_byte};
      LBU:     rdata = {{(XLEN-8){1'b0}}, w_byte};
      LH:      rdata = {{(XLEN-16){w_half[15]}}, w_half};
      LHU:     rdata = {{(XLEN-16){1'b0}}, w_half};
      LW:      rdata = rdata_word;
      default: rdata = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : data_mem_pipe                                                   |
// | Purpose  : Pipelined RV32 load/store data memory. Valid/ready request,     |
// |            fixed READ_LAT response latency, byte/half/word access,         |
// |            error reporting and optional zero-clear after reset.            |
// | Ports    : clk, rst (async, active-high)                                   |
// |            req_valid/req_ready/req_ctrl/req_addr/req_wdata - request       |
// |            rsp_valid/rsp_rdata/rsp_err                     - response      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module data_mem_pipe
  import dmem_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LAT     = 1,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_ctrl,
  input  logic [31:0]     req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int                 c_idx_w    = $clog2(DEPTH_WORDS);
  localparam int                 c_nbytes   = XLEN / 8;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(DEPTH_WORDS - 1);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_e;

  state_e             r_state;
  logic [c_idx_w-1:0] r_clr_idx;
  logic               r_ready;

  // Clear FSM: one zero word per cycle, then RUN with req_ready held high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if (CLEAR_ON_RST != 0) r_state <= S_CLEAR;
      else                   r_state <= S_RUN;
      r_clr_idx <= '0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (r_clr_idx == c_last_idx) begin
            r_state <= S_RUN;
            r_ready <= 1'b1;
          end else begin
            r_clr_idx <= r_clr_idx + 1'b1;
          end
        end
        default: r_ready <= 1'b1;
      endcase
    end
  end

  assign req_ready = r_ready;

  // Request decode. Any address bit above the word index makes the access
  // out of range, so no address aliases onto a real location.
  logic               w_accept;
  logic [c_idx_w-1:0] w_idx;
  logic               w_oor;
  logic               w_err;
  logic               w_st_we;

  assign w_accept = req_valid & r_ready;
  assign w_idx    = req_addr[c_idx_w+1:2];
  assign w_oor    = |req_addr[31:c_idx_w+2];
  assign w_err    = req_ctrl[3] | misaligned(req_ctrl, req_addr[1:0]) | w_oor;
  assign w_st_we  = w_accept & is_store(req_ctrl) & ~w_err;

  // Write port shared by the clear walker and stores; ready is low during
  // CLEAR so the two never compete.
  logic [c_nbytes-1:0] w_be;
  logic [XLEN-1:0]     w_wdata;
  logic [c_idx_w-1:0]  w_widx;

  always_comb begin
    w_be    = '0;
    w_wdata = req_wdata;
    w_widx  = w_idx;
    case (acc_size(req_ctrl))
      SZ_BYTE: begin
        w_be    = 4'b0001 << req_addr[1:0];
        w_wdata = {c_nbytes{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {(c_nbytes/2){req_wdata[15:0]}};
      end
      default: w_be = '1;
    endcase
    if (!w_st_we) w_be = '0;
    if (r_state == S_CLEAR) begin
      w_be    = '1;
      w_wdata = '0;
      w_widx  = r_clr_idx;
    end
  end

  logic [XLEN-1:0] r_mem [DEPTH_WORDS];
  logic [XLEN-1:0] r_rd_word;

  // Read-old semantics: a load one cycle after a store sees the new data
  // because the store has already landed on the previous edge.
  always_ff @(posedge clk) begin
    for (int b = 0; b < c_nbytes; b++) begin
      if (w_be[b]) r_mem[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
    end
    if (w_accept) r_rd_word <= r_mem[w_idx];
  end

  // Stage 1: request attributes registered alongside the array read.
  logic       r_s1_valid;
  logic       r_s1_err;
  logic [3:0] r_s1_ctrl;
  logic [1:0] r_s1_off;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_ctrl  <= '0;
      r_s1_off   <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_err  <= w_err;
        r_s1_ctrl <= req_ctrl;
        r_s1_off  <= req_addr[1:0];
      end
    end
  end

  logic [XLEN-1:0] w_aligned;
  logic [XLEN-1:0] w_s1_data;
  logic            w_s1_err;

  dmem_load_align #(.XLEN(XLEN)) u_align (
    .rdata_word (r_rd_word),
    .off        (r_s1_off),
    .ctrl       (r_s1_ctrl),
    .rdata      (w_aligned)
  );

  // Data and err are forced to 0 outside a valid load so idle cycles,
  // store acks and errors all present a clean zero.
  assign w_s1_data = (r_s1_valid && !r_s1_err && !is_store(r_s1_ctrl)) ? w_aligned : '0;
  assign w_s1_err  = r_s1_valid & r_s1_err;

  generate
    if (READ_LAT <= 1) begin : g_lat1
      assign rsp_valid = r_s1_valid;
      assign rsp_rdata = w_s1_data;
      assign rsp_err   = w_s1_err;
    end else begin : g_latn
      localparam int c_stages = READ_LAT - 1;

      logic [c_stages-1:0]           r_pv;
      logic [c_stages-1:0]           r_pe;
      logic [c_stages-1:0][XLEN-1:0] r_pd;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_pv <= '0;
          r_pe <= '0;
          r_pd <= '0;
        end else begin
          r_pv[0] <= r_s1_valid;
          r_pe[0] <= w_s1_err;
          r_pd[0] <= w_s1_data;
          for (int i = 1; i < c_stages; i++) begin
            r_pv[i] <= r_pv[i-1];
            r_pe[i] <= r_pe[i-1];
            r_pd[i] <= r_pd[i-1];
          end
        end
      end

      assign rsp_valid = r_pv[c_stages-1];
      assign rsp_rdata = r_pd[c_stages-1];
      assign rsp_err   = r_pe[c_stages-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_data_mem_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_data_mem_pipe                                                |
// | Purpose  : Directed self-checking bench for data_mem_pipe                  |
// |            (DEPTH_WORDS=16, READ_LAT=3, CLEAR_ON_RST=1).                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_data_mem_pipe;

  localparam int XLEN  = 32;
  localparam int DEPTH = 16;
  localparam int LAT   = 3;

  localparam logic [3:0] c_lb  = 4'd0;
  localparam logic [3:0] c_lh  = 4'd1;
  localparam logic [3:0] c_lw  = 4'd2;
  localparam logic [3:0] c_lbu = 4'd3;
  localparam logic [3:0] c_lhu = 4'd4;
  localparam logic [3:0] c_sb  = 4'd5;
  localparam logic [3:0] c_sh  = 4'd6;
  localparam logic [3:0] c_sw  = 4'd7;

  logic            clk       = 1'b0;
  logic            rst       = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [3:0]      req_ctrl  = '0;
  logic [31:0]     req_addr  = '0;
  logic [XLEN-1:0] req_wdata = '0;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  data_mem_pipe #(
    .XLEN         (XLEN),
    .DEPTH_WORDS  (DEPTH),
    .READ_LAT     (LAT),
    .CLEAR_ON_RST (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_ctrl  (req_ctrl),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
    string       tag;
  } exp_t;

  exp_t q[$];

  // Every cycle is checked: either the oldest expected response is due now,
  // or the response port must be idle (valid=0, rdata=0, err=0).
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due == cyc) begin
      check({q[0].tag, "_valid"}, 32'(rsp_valid), 32'd1);
      check({q[0].tag, "_rdata"}, rsp_rdata, q[0].data);
      check({q[0].tag, "_err"}, 32'(rsp_err), 32'(q[0].err));
      void'(q.pop_front());
    end else begin
      check("idle_valid", 32'(rsp_valid), 32'd0);
      check("idle_rdata", rsp_rdata, 32'd0);
      check("idle_err", 32'(rsp_err), 32'd0);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge so the
  // next call can follow back-to-back.
  task automatic req(input string tag, input logic [3:0] ctrl, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_data, input logic exp_err);
    exp_t e;
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_ctrl  = ctrl;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    e.due  = cyc + LAT - 1;
    e.data = exp_data;
    e.err  = exp_err;
    e.tag  = tag;
    q.push_back(e);
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, 32'(n), 32'(DEPTH));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset and hardware clear
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    wait_ready("clear_len");
    req("lw_3c_clr", c_lw, 32'h3C, 32'h0, 32'h0, 1'b0);

    // 2. word store then every load flavour
    req("sw_08",  c_sw,  32'h08, 32'h12345678, 32'h0,        1'b0);
    req("lb_08",  c_lb,  32'h08, 32'h0,        32'h00000078, 1'b0);
    req("lbu_0b", c_lbu, 32'h0B, 32'h0,        32'h00000012, 1'b0);
    req("lh_0a",  c_lh,  32'h0A, 32'h0,        32'h00001234, 1'b0);
    req("lhu_0a", c_lhu, 32'h0A, 32'h0,        32'h00001234, 1'b0);
    req("lw_08",  c_lw,  32'h08, 32'h0,        32'h12345678, 1'b0);
    req("lh_08",  c_lh,  32'h08, 32'h0,        32'h00005678, 1'b0);

    // 3. sub-word stores, sign vs zero extension, untouched lanes
    req("sb_09",  c_sb,  32'h09, 32'hAAAAAA80, 32'h0,        1'b0);
    req("lb_09",  c_lb,  32'h09, 32'h0,        32'hFFFFFF80, 1'b0);
    req("lbu_09", c_lbu, 32'h09, 32'h0,        32'h00000080, 1'b0);
    req("lw_08b", c_lw,  32'h08, 32'h0,        32'h12348078, 1'b0);
    req("sh_0e",  c_sh,  32'h0E, 32'h1234BEEF, 32'h0,        1'b0);
    req("lh_0e",  c_lh,  32'h0E, 32'h0,        32'hFFFFBEEF, 1'b0);
    req("lhu_0e", c_lhu, 32'h0E, 32'h0,        32'h0000BEEF, 1'b0);
    req("lw_0c",  c_lw,  32'h0C, 32'h0,        32'hBEEF0000, 1'b0);
    idle(LAT + 1);

    // 4. errors leave memory untouched
    req("sw_00",   c_sw,  32'h00,        32'hCAFEF00D, 32'h0, 1'b0);
    req("lw_02",   c_lw,  32'h02,        32'h0,        32'h0, 1'b1);
    req("sh_01",   c_sh,  32'h01,        32'h0000FFFF, 32'h0, 1'b1);
    req("ill_9",   4'd9,  32'h00,        32'h11111111, 32'h0, 1'b1);
    req("sw_40",   c_sw,  32'h40,        32'hDEADBEEF, 32'h0, 1'b1);
    req("sw_hi",   c_sw,  32'h80000000,  32'h55555555, 32'h0, 1'b1);
    req("lw_40",   c_lw,  32'h40,        32'h0,        32'h0, 1'b1);
    req("lhu_03",  c_lhu, 32'h03,        32'h0,        32'h0, 1'b1);
    req("lw_00",   c_lw,  32'h00,        32'h0,        32'hCAFEF00D, 1'b0);
    req("sb_3f",   c_sb,  32'h3F,        32'h00000099, 32'h0, 1'b0);
    req("lb_3f",   c_lb,  32'h3F,        32'h0,        32'hFFFFFF99, 1'b0);
    req("lw_3c",   c_lw,  32'h3C,        32'h0,        32'h99000000, 1'b0);
    idle(LAT + 1);

    // 5. back-to-back store/load, fixed latency
    req("sw_04", c_sw, 32'h04, 32'h0BADC0DE, 32'h0,        1'b0);
    req("lw_04", c_lw, 32'h04, 32'h0,        32'h0BADC0DE, 1'b0);
    idle(LAT + 2);

    // 6. reset with two loads in flight, then reset mid-clear
    req("fl_a", c_lw, 32'h04, 32'h0, 32'h0, 1'b0);
    req("fl_b", c_lw, 32'h00, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    q.delete();
    idle(2);
    check("rst2_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    idle(5);
    check("midclr_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    wait_ready("clear_restart");
    req("lw_04_clr", c_lw, 32'h04, 32'h0, 32'h0, 1'b0);
    req("lw_00_clr", c_lw, 32'h00, 32'h0, 32'h0, 1'b0);
    req("lw_08_clr", c_lw, 32'h08, 32'h0, 32'h0, 1'b0);
    idle(LAT + 2);

    check("drain", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
